rsa_modexp: RTL and testbench
=============================

# rsa_modexp

Parametrised memory-mapped RSA modular-exponentiation engine on the APB-style peripheral bus. It computes msg^exp mod M for KEY_W-bit operands using an internal radix-2 Montgomery multiplier. Software loads operands 32 bits at a time through a word-select register, starts the engine, and polls or takes an interrupt. It replaces the fixed 64-bit engine as the lock controller's crypto slave.

## Interface
- KEY_W, 64: operand width in bits; a multiple of 32, from 64 to 512.
- pclk  in  1  clock.
- nreset  in  1  synchronous, active-low reset.
- bus_write_en  in  1  bus write strobe.
- bus_read_en  in  1  bus read strobe.
- rsa_enable  in  1  slave select; accesses are ignored when it is 0.
- bus_addr  in  8  register address.
- bus_write_data  in  32  write data.
- bus_read_data  out  32  read data; combinational in the read cycle; 0 when not reading.
- result_valid  out  1  result register holds a finished result.
- busy  out  1  exponentiation in progress.
- irq  out  1  one-cycle pulse on completion when CTRL.irq_en=1.

## Operation
- Register map (W = KEY_W/32 words, index 0 = least significant word):
  - 0x08 WORD_SEL (R/W). Word index; writes are taken modulo W.
  - 0x0C MSG, 0x10 MOD, 0x14 EXP, 0x18 RES (W). Each write lands in the word selected by WORD_SEL. RES must hold R² mod M, with R = 2^KEY_W. Any of these writes clears result_valid. Writes while busy are ignored.
  - 0x1C CTRL (R/W). Bit 0 start, bit 1 irq_en, bit 2 abort. Start and abort are self-clearing and read back as 0.
  - 0x20 RESULT (R). Returns the word selected by WORD_SEL.
  - 0x24 STATUS (R). Bit 0 valid, bit 1 busy, bit 2 err.
- Start:
  - Ignored while busy.
  - If MOD[0]=0 (even modulus), err is set, result_valid stays 0 and busy stays 0.
  - Otherwise err is cleared, result_valid is cleared, busy is set and the FSM leaves IDLE.
- FSM states: IDLE → TO_ONE → TO_MONT → LOOP_MUL ↔ LOOP_SQR → FROM_MONT → DONE → IDLE.
  - TO_ONE: one = MM(RES, 1).
  - TO_MONT: Z = MM(RES, MSG).
  - Loop over bit i, from 0 up to a last bit L:
    - LOOP_MUL: if EXP[i]=1, acc = MM(acc, Z). acc is initialised to one.
    - LOOP_SQR: Z = MM(Z, Z).
  - FROM_MONT: RESULT = MM(acc, 1).
  - DONE: set result_valid, pulse irq, clear busy.
- MM(a, b) = a·b·R⁻¹ mod M. It is fully reduced to [0, M) by a final conditional subtraction. Internal accumulators are KEY_W+2 bits wide.
- MSG ≥ M produces an undefined result. This is not detected.
- Abort, or reset, at any point: return to IDLE and clear busy and result_valid. No irq pulse. An in-flight multiply is discarded.

## Timing
- Reset values: bus_read_data=0, result_valid=0, busy=0, irq=0. All operand registers, WORD_SEL, CTRL and err are reset to 0.
- The write is sampled at edge 0, and busy=1 after edge 0.
- Each multiply state costs KEY_W+3 cycles: 1 cycle to issue start, then KEY_W+2 cycles for the multiplier, whose done pulses exactly KEY_W+2 cycles after start.
- result_valid, irq and busy=0 all take effect at the same edge, N·(KEY_W+3)+1 cycles after busy rises. N is the multiply count defined under Configuration.
- A start written in the same cycle that DONE completes is ignored, because busy is still 1.

## Configuration
- RSA_CONST_TIME_EN defined:
  - L = KEY_W−1. Every bit performs both LOOP_MUL and LOOP_SQR.
  - For a 0 bit the LOOP_MUL result is computed and then discarded.
  - N = 3 + 2·KEY_W, independent of EXP.
- RSA_CONST_TIME_EN undefined:
  - L = index of the most significant set bit of EXP.
  - LOOP_MUL is skipped, costing 0 cycles, when EXP[i]=0.
  - LOOP_SQR is skipped for i=L.
  - EXP=0 skips the loop entirely.
  - N = 3 + popcount(EXP) + L.

## Structure
- rsa_pkg holds:
  - the register address constants;
  - the FSM state enum;
  - the CTRL and STATUS bit positions;
  - the KEY_W legality check function.
- Sub-module rsa_mont_mult (parameter KEY_W):
  - ports: pclk, nreset, start, a, b, m, p, done;
  - radix-2 bit-serial, KEY_W iterations, plus 1 cycle for the final subtract and 1 cycle for the done pulse.

## Test plan
- KEY_W=64, M=13, RES=9, MSG=5, EXP=3, start → RESULT word0=8, word1=0, valid=1, irq pulses once. In const-time mode valid rises 131·67+1 cycles after busy.
- EXP=0 → RESULT=1. EXP=1 → RESULT=5. In non-const-time mode, EXP=0 takes 3·67+1 cycles.
- MOD=14 (even), start → err=1, busy and valid stay 0, no irq.
- KEY_W=128: write 4 words of each operand using WORD_SEL, with M=2^127+1 (an odd modulus), MSG=2, EXP=10, RES precomputed. Expected RESULT=1024, read back word by word with WORD_SEL=0..3. WORD_SEL=5 aliases to word 1.
- Abort at cycle 500, then separately nreset=0 at cycle 500 → busy=0, valid=0, no irq. A fresh start then gives the correct result.
- Write MSG while busy → ignored, and the result matches the original MSG. A second start while busy → ignored, and the latency is unchanged.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation slave:
// register map, control/status bit positions, FSM states and KEY_W check.
package rsa_pkg;

    localparam logic [7:0] ADDR_WORD_SEL = 8'h08;
    localparam logic [7:0] ADDR_MSG      = 8'h0C;
    localparam logic [7:0] ADDR_MOD      = 8'h10;
    localparam logic [7:0] ADDR_EXP      = 8'h14;
    localparam logic [7:0] ADDR_RES      = 8'h18;
    localparam logic [7:0] ADDR_CTRL     = 8'h1C;
    localparam logic [7:0] ADDR_RESULT   = 8'h20;
    localparam logic [7:0] ADDR_STATUS   = 8'h24;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_VALID = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_ERR   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_ONE,
        ST_TO_MONT,
        ST_LOOP_MUL,
        ST_LOOP_SQR,
        ST_FROM_MONT,
        ST_DONE
    } rsa_state_t;

    function automatic bit key_w_ok(input int kw);
        return (kw % 32 == 0) && (kw >= 64) && (kw <= 512);
    endfunction

endpackage

// File: rtl/rsa_mont_mult.sv
// Radix-2 bit-serial Montgomery multiplier: p = a*b*2^-KEY_W mod m.
// KEY_W iterations, one final-subtract cycle, then a one-cycle done pulse.
module rsa_mont_mult #(
    parameter int KEY_W = 64
) (
    input  logic             pclk,
    input  logic             nreset,
    input  logic             start,
    input  logic [KEY_W-1:0] a,
    input  logic [KEY_W-1:0] b,
    input  logic [KEY_W-1:0] m,
    output logic [KEY_W-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(KEY_W);

    logic [KEY_W-1:0] a_sh, b_r, m_r, fin;
    logic [KEY_W+1:0] acc, sum, red, m_x;
    logic [CW-1:0]    cnt;
    logic             run, sub;

    always_comb begin
        m_x = {2'b00, m_r};
        sum = acc + (a_sh[0] ? {2'b00, b_r} : '0);
        red = sum + (sum[0] ? m_x : '0);
        fin = (acc >= m_x) ? KEY_W'(acc - m_x) : acc[KEY_W-1:0];
    end

    // A new start always wins, so an abandoned product never leaks out.
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            a_sh <= '0;
            b_r  <= '0;
            m_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            sub  <= 1'b0;
            p    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_sh <= a;
                b_r  <= b;
                m_r  <= m;
                acc  <= '0;
                cnt  <= '0;
                run  <= 1'b1;
                sub  <= 1'b0;
            end else if (run) begin
                acc  <= red >> 1;
                a_sh <= a_sh >> 1;
                cnt  <= cnt + CW'(1);
                if (cnt == CW'(KEY_W - 1)) begin
                    run <= 1'b0;
                    sub <= 1'b1;
                end
            end else if (sub) begin
                p    <= fin;
                done <= 1'b1;
                sub  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_modexp.sv
// RSA msg^exp mod M bus slave built around rsa_mont_mult.
// Define RSA_CONST_TIME_EN for an exponent-independent multiply schedule.
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int KEY_W = 64
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        bus_write_en,
    input  logic        bus_read_en,
    input  logic        rsa_enable,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        result_valid,
    output logic        busy,
    output logic        irq
);

    localparam int W   = KEY_W / 32;
    localparam int WSW = $clog2(W);
    localparam int BW  = WSW + 5;
    localparam int IW  = $clog2(KEY_W);
    localparam logic [31:0]      W_L = 32'(W);
    localparam logic [KEY_W-1:0] ONE = KEY_W'(1);

    if (!key_w_ok(KEY_W)) begin : g_bad_key_w
        $error("rsa_modexp: illegal KEY_W %0d", KEY_W);
    end

    rsa_state_t state, state_nxt, first_st, mul_nxt, sqr_nxt;

    logic [KEY_W-1:0] msg_r, mod_r, exp_r, res_r;
    logic [KEY_W-1:0] acc_r, z_r, out_r;
    logic [KEY_W-1:0] mm_a, mm_b, mm_p;
    logic [WSW-1:0]   ws;
    logic [BW-1:0]    ws_lsb;
    logic [IW-1:0]    idx;
    logic wr, rd, op_wr, start_req, abort_req, go;
    logic irq_en, err, mm_pend, mm_start, mm_done, mm_fin;
    logic idx_inc, exp_bit;

    assign wr        = bus_write_en && rsa_enable;
    assign rd        = bus_read_en && rsa_enable;
    assign busy      = (state != ST_IDLE);
    assign ws_lsb    = {ws, 5'b00000};
    assign abort_req = wr && bus_addr == ADDR_CTRL
                       && bus_write_data[CTRL_ABORT];
    assign start_req = wr && bus_addr == ADDR_CTRL && !abort_req
                       && bus_write_data[CTRL_START] && !busy;
    assign go        = start_req && mod_r[0];
    assign op_wr     = wr && !busy && (bus_addr == ADDR_MSG
                       || bus_addr == ADDR_MOD || bus_addr == ADDR_EXP
                       || bus_addr == ADDR_RES);
    assign mm_fin    = mm_pend && mm_done;
    assign exp_bit   = exp_r[idx];

`ifdef RSA_CONST_TIME_EN
    assign first_st = ST_LOOP_MUL;
    assign mul_nxt  = ST_LOOP_SQR;
    assign sqr_nxt  = (idx == IW'(KEY_W - 1)) ? ST_FROM_MONT : ST_LOOP_MUL;
`else
    logic [IW-1:0] last_bit, idx_nxt;

    always_comb begin
        last_bit = '0;
        for (int i = 0; i < KEY_W; i++)
            if (exp_r[i]) last_bit = IW'(i);
    end

    assign idx_nxt  = idx + IW'(1);
    assign first_st = (exp_r == '0) ? ST_FROM_MONT
                    : (exp_r[0] ? ST_LOOP_MUL : ST_LOOP_SQR);
    assign mul_nxt  = (idx == last_bit) ? ST_FROM_MONT : ST_LOOP_SQR;
    assign sqr_nxt  = exp_r[idx_nxt] ? ST_LOOP_MUL : ST_LOOP_SQR;
`endif

    always_ff @(posedge pclk) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mm_start  = 1'b0;
        mm_a      = acc_r;
        mm_b      = z_r;
        idx_inc   = 1'b0;
        unique case (state)
            ST_IDLE: if (go) state_nxt = ST_TO_ONE;
            ST_TO_ONE: begin
                mm_start = !mm_pend;
                mm_a     = res_r;
                mm_b     = ONE;
                if (mm_fin) state_nxt = ST_TO_MONT;
            end
            ST_TO_MONT: begin
                mm_start = !mm_pend;
                mm_a     = res_r;
                mm_b     = msg_r;
                if (mm_fin) state_nxt = first_st;
            end
            ST_LOOP_MUL: begin
                mm_start = !mm_pend;
                if (mm_fin) state_nxt = mul_nxt;
            end
            ST_LOOP_SQR: begin
                mm_start = !mm_pend;
                mm_a     = z_r;
                if (mm_fin) begin
                    state_nxt = sqr_nxt;
                    idx_inc   = 1'b1;
                end
            end
            ST_FROM_MONT: begin
                mm_start = !mm_pend;
                mm_b     = ONE;
                if (mm_fin) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_req) state_nxt = ST_IDLE;
    end

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            msg_r        <= '0;
            mod_r        <= '0;
            exp_r        <= '0;
            res_r        <= '0;
            acc_r        <= '0;
            z_r          <= '0;
            out_r        <= '0;
            ws           <= '0;
            idx          <= '0;
            irq_en       <= 1'b0;
            err          <= 1'b0;
            mm_pend      <= 1'b0;
            result_valid <= 1'b0;
            irq          <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (wr && bus_addr == ADDR_WORD_SEL)
                ws <= WSW'(bus_write_data % W_L);
            if (wr && bus_addr == ADDR_CTRL)
                irq_en <= bus_write_data[CTRL_IRQ_EN];
            if (op_wr) begin
                result_valid <= 1'b0;
                case (bus_addr)
                    ADDR_MSG: msg_r[ws_lsb +: 32] <= bus_write_data;
                    ADDR_MOD: mod_r[ws_lsb +: 32] <= bus_write_data;
                    ADDR_EXP: exp_r[ws_lsb +: 32] <= bus_write_data;
                    default:  res_r[ws_lsb +: 32] <= bus_write_data;
                endcase
            end
            if (start_req) begin
                err <= !mod_r[0];
                if (mod_r[0]) begin
                    result_valid <= 1'b0;
                    idx          <= '0;
                    mm_pend      <= 1'b0;
                end
            end
            if (mm_start) mm_pend <= 1'b1;
            if (mm_fin) begin
                mm_pend <= 1'b0;
                case (state)
                    ST_TO_ONE:               acc_r <= mm_p;
                    ST_TO_MONT, ST_LOOP_SQR: z_r   <= mm_p;
                    ST_LOOP_MUL: if (exp_bit) acc_r <= mm_p;
                    ST_FROM_MONT:            out_r <= mm_p;
                    default: ;
                endcase
            end
            if (idx_inc) idx <= idx + IW'(1);
            if (state == ST_DONE) begin
                result_valid <= 1'b1;
                irq          <= irq_en;
            end
            if (abort_req) begin
                result_valid <= 1'b0;
                irq          <= 1'b0;
                mm_pend      <= 1'b0;
            end
        end
    end

    always_comb begin
        bus_read_data = '0;
        if (rd) begin
            case (bus_addr)
                ADDR_WORD_SEL: bus_read_data = 32'(ws);
                ADDR_CTRL:     bus_read_data[CTRL_IRQ_EN] = irq_en;
                ADDR_RESULT:   bus_read_data = out_r[ws_lsb +: 32];
                ADDR_STATUS: begin
                    bus_read_data[STAT_VALID] = result_valid;
                    bus_read_data[STAT_BUSY]  = busy;
                    bus_read_data[STAT_ERR]   = err;
                end
                default: ;
            endcase
        end
    end

    rsa_mont_mult #(.KEY_W(KEY_W)) u_mm (
        .pclk   (pclk),
        .nreset (nreset),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .m      (mod_r),
        .p      (mm_p),
        .done   (mm_done)
    );

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed bench for rsa_modexp at KEY_W=64 and KEY_W=128.
// Results are hand-derived; latency follows the multiply-count model.
module tb_rsa_modexp;
    import rsa_pkg::*;

    logic        pclk = 1'b0;
    logic        nreset = 1'b0;
    logic        bus_write_en = 1'b0;
    logic        bus_read_en = 1'b0;
    logic [7:0]  bus_addr = '0;
    logic [31:0] bus_write_data = '0;
    logic        tgt128 = 1'b0;

    logic [31:0] rd64, rd128, c_rd, rd_other;
    logic        v64, v128, b64, b128, i64, i128;
    logic        c_valid, c_busy, c_irq;

    int n_chk = 0;
    int n_fail = 0;
    int irq_cnt64 = 0;
    int irq_cnt128 = 0;

    always #5 pclk = ~pclk;

    rsa_modexp #(.KEY_W(64)) u64 (
        .pclk(pclk), .nreset(nreset),
        .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
        .rsa_enable(!tgt128), .bus_addr(bus_addr),
        .bus_write_data(bus_write_data), .bus_read_data(rd64),
        .result_valid(v64), .busy(b64), .irq(i64)
    );

    rsa_modexp #(.KEY_W(128)) u128 (
        .pclk(pclk), .nreset(nreset),
        .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
        .rsa_enable(tgt128), .bus_addr(bus_addr),
        .bus_write_data(bus_write_data), .bus_read_data(rd128),
        .result_valid(v128), .busy(b128), .irq(i128)
    );

    assign c_rd    = tgt128 ? rd128 : rd64;
    assign c_valid = tgt128 ? v128 : v64;
    assign c_busy  = tgt128 ? b128 : b64;
    assign c_irq   = tgt128 ? i128 : i64;

    always @(negedge pclk) begin
        if (i64)  irq_cnt64++;
        if (i128) irq_cnt128++;
    end

    function automatic int irqs();
        return tgt128 ? irq_cnt128 : irq_cnt64;
    endfunction

    function automatic int exp_lat(input int k, input logic [31:0] e);
        int pop, msb, n;
        pop = 0;
        msb = 0;
        for (int i = 0; i < 32; i++)
            if (e[i]) begin
                pop++;
                msb = i;
            end
`ifdef RSA_CONST_TIME_EN
        n = 3 + 2 * k;
`else
        n = (e == 0) ? 3 : 3 + pop + msb;
`endif
        return n * (k + 3) + 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge pclk);
        bus_addr       = a;
        bus_write_data = d;
        bus_write_en   = 1'b1;
        @(posedge pclk);
        #1;
        bus_write_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge pclk);
        bus_addr    = a;
        bus_read_en = 1'b1;
        #1;
        d        = c_rd;
        rd_other = tgt128 ? rd64 : rd128;
        bus_read_en = 1'b0;
    endtask

    task automatic rd_word(input logic [31:0] w, output logic [31:0] d);
        wr(ADDR_WORD_SEL, w);
        rd(ADDR_RESULT, d);
    endtask

    task automatic wait_done(input int t0, input int lat, input string nm);
        int  cyc;
        bit  seen;
        cyc  = t0;
        seen = 1'b0;
        while (!seen && cyc < 40000) begin
            @(posedge pclk);
            #1;
            cyc++;
            seen = c_valid;
        end
        check({nm, " latency"}, cyc, lat);
        check({nm, " busy at done"}, {31'b0, c_busy}, 0);
        check({nm, " irq at done"}, {31'b0, c_irq}, 1);
    endtask

    typedef struct {
        logic [31:0] msg;
        logic [31:0] modv;
        logic [31:0] expv;
        logic [31:0] res;
        logic [31:0] want;
    } vec_t;

    vec_t        vt[3];
    logic [31:0] d;
    logic [31:0] msg128[4], mod128[4], exp128[4], res128[4], want128[4];
    int          ic;

    task automatic load64(input vec_t v);
        wr(ADDR_WORD_SEL, 0);
        wr(ADDR_MSG, v.msg);
        wr(ADDR_MOD, v.modv);
        wr(ADDR_EXP, v.expv);
        wr(ADDR_RES, v.res);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // R = 2^64: R mod 13 = 3, R^2 mod 13 = 9
        vt[0] = '{msg: 5, modv: 13, expv: 3, res: 9, want: 8};
        vt[1] = '{msg: 5, modv: 13, expv: 0, res: 9, want: 1};
        vt[2] = '{msg: 5, modv: 13, expv: 1, res: 9, want: 5};
        // M = 2^127+1: 2^128 = -2, so R^2 mod M = 4
        msg128  = '{32'd2, 32'd0, 32'd0, 32'd0};
        mod128  = '{32'd1, 32'd0, 32'd0, 32'h8000_0000};
        exp128  = '{32'd10, 32'd0, 32'd0, 32'd0};
        res128  = '{32'd4, 32'd0, 32'd0, 32'd0};
        want128 = '{32'd1024, 32'd0, 32'd0, 32'd0};

        tick(3);
        check("reset valid", {31'b0, v64}, 0);
        check("reset busy", {31'b0, b64}, 0);
        check("reset irq", {31'b0, i64}, 0);
        check("idle read data", rd64, 0);
        check("reset busy 128", {31'b0, b128}, 0);
        @(negedge pclk);
        nreset = 1'b1;
        rd(ADDR_STATUS, d);
        check("reset status", d, 0);
        rd(ADDR_WORD_SEL, d);
        check("reset word_sel", d, 0);

        for (int k = 0; k < 3; k++) begin
            load64(vt[k]);
            check($sformatf("vec%0d valid cleared", k), {31'b0, v64}, 0);
            ic = irqs();
            wr(ADDR_CTRL, 32'h3);
            check($sformatf("vec%0d busy after start", k), {31'b0, b64}, 1);
            wait_done(0, exp_lat(64, vt[k].expv), $sformatf("vec%0d", k));
            tick(3);
            check($sformatf("vec%0d irq count", k), irqs() - ic, 1);
            rd_word(0, d);
            check($sformatf("vec%0d result w0", k), d, vt[k].want);
            rd_word(1, d);
            check($sformatf("vec%0d result w1", k), d, 0);
            rd(ADDR_STATUS, d);
            check($sformatf("vec%0d status", k), d, 32'h1);
        end
        wr(ADDR_WORD_SEL, 0);
        rd(ADDR_CTRL, d);
        check("ctrl readback", d, 32'h2);

        wr(ADDR_MOD, 14);
        ic = irqs();
        wr(ADDR_CTRL, 32'h3);
        check("even mod busy", {31'b0, b64}, 0);
        tick(5);
        check("even mod valid", {31'b0, v64}, 0);
        rd(ADDR_STATUS, d);
        check("even mod status", d, 32'h4);
        check("even mod irq", irqs() - ic, 0);
        wr(ADDR_MOD, 13);

        wr(ADDR_EXP, 32'hFFFF);
        wr(ADDR_CTRL, 32'h3);
        tick(499);
        ic = irqs();
        wr(ADDR_CTRL, 32'h6);
        check("abort busy", {31'b0, b64}, 0);
        check("abort valid", {31'b0, v64}, 0);
        tick(300);
        check("abort irq", irqs() - ic, 0);
        rd(ADDR_STATUS, d);
        check("abort status", d, 0);

        wr(ADDR_CTRL, 32'h3);
        tick(499);
        ic = irqs();
        @(negedge pclk);
        nreset = 1'b0;
        @(posedge pclk);
        #1;
        check("reset mid-run busy", {31'b0, b64}, 0);
        check("reset mid-run valid", {31'b0, v64}, 0);
        @(negedge pclk);
        nreset = 1'b1;
        tick(300);
        check("reset mid-run irq", irqs() - ic, 0);
        rd(ADDR_CTRL, d);
        check("reset ctrl", d, 0);

        // R^2 mod 11 = 3; 7^2 mod 11 = 5, 9^2 mod 11 = 4
        load64('{msg: 7, modv: 11, expv: 2, res: 3, want: 5});
        ic = irqs();
        wr(ADDR_CTRL, 32'h3);
        check("fresh busy", {31'b0, b64}, 1);
        tick(20);
        wr(ADDR_MSG, 9);
        tick(50);
        wr(ADDR_CTRL, 32'h3);
        wait_done(72, exp_lat(64, 2), "fresh");
        tick(3);
        check("fresh irq count", irqs() - ic, 1);
        rd_word(0, d);
        check("fresh result", d, 5);

        tgt128 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr(ADDR_WORD_SEL, i);
            wr(ADDR_MSG, msg128[i]);
            wr(ADDR_MOD, mod128[i]);
            wr(ADDR_EXP, exp128[i]);
            wr(ADDR_RES, res128[i]);
        end
        ic = irqs();
        wr(ADDR_CTRL, 32'h3);
        check("k128 busy", {31'b0, b128}, 1);
        wait_done(0, exp_lat(128, 10), "k128");
        tick(3);
        check("k128 irq count", irqs() - ic, 1);
        for (int i = 0; i < 4; i++) begin
            rd_word(i, d);
            check($sformatf("k128 result w%0d", i), d, want128[i]);
        end
        check("unselected read zero", rd_other, 0);
        wr(ADDR_WORD_SEL, 5);
        rd(ADDR_WORD_SEL, d);
        check("k128 word_sel wrap", d, 1);
        rd(ADDR_RESULT, d);
        check("k128 alias word", d, want128[1]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
